cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the 4-bit combinational CLA, built from 4-bit lookahead groups.
- One pipeline stage per 4-bit group.
- Input and output use a valid/ready handshake.
- Supports add and subtract modes and produces carry, signed-overflow and zero flags.
- Feeds the ALU datapath wherever a wide adder would otherwise break timing.

---
 rtl/cla_pipe_adder_pkg.sv | 17 +
 rtl/cla_group4.sv | 38 +++
 rtl/cla_pipe_adder.sv | 143 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder.
package cla_pipe_adder_pkg;

    // Every lookahead group, and therefore every pipeline stage, is one nibble wide.
    localparam int GROUP_W = 4;

    // The number of groups equals the number of stages and the latency in cycles.
    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

    // The operand width must be a non-zero whole number of groups.
    function automatic bit width_legal(input int width);
        return (width >= GROUP_W) && ((width % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group. All internal carries come from the
// flattened lookahead equations, so no carry ripples from bit to bit.
module cla_group4
    import cla_pipe_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a4,
    input  logic [GROUP_W-1:0] b4,
    input  logic               c,
    output logic [GROUP_W-1:0] s4,
    output logic               p,
    output logic               g,
    output logic               c3,
    output logic               co
);

    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] cv;

    assign pb = a4 ^ b4;
    assign gb = a4 & b4;

    // Per-bit carries, each a two-level function of the group inputs and c.
    assign cv[0] = c;
    assign cv[1] = gb[0] | (pb[0] & c);
    assign cv[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c);
    assign cv[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & c);

    // Group propagate/generate and the group carry they imply.
    assign p  = &pb;
    assign g  = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
              | (pb[3] & pb[2] & pb[1] & gb[0]);
    assign co = g | (p & c);
    assign c3 = cv[3];
    assign s4 = pb ^ cv;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one stage per 4-bit group,
// operands skewed forward, computed nibbles deskewed, valid/ready at both ends.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = num_groups(WIDTH);

    if (!width_legal(WIDTH)) begin : g_width_chk
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    logic             adv;
    logic [WIDTH-1:0] eb;
    logic             ec;
    logic [NG-1:0]    vld_pipe;

    // Per-stage registers: skewed operands, deskewed sum, carries.
    logic [WIDTH-1:0] a_sk   [NG];
    logic [WIDTH-1:0] b_sk   [NG];
    logic [WIDTH-1:0] sum_dk [NG];
    logic             c_q    [NG];
    logic             c3_q   [NG];
    logic             zero_q;

    // Per-stage combinational values around each lookahead group.
    logic [GROUP_W-1:0] grp_a [NG];
    logic [GROUP_W-1:0] grp_b [NG];
    logic               grp_c [NG];
    logic [GROUP_W-1:0] s_n   [NG];
    logic               p_n   [NG];
    logic               g_n   [NG];
    logic               c3_n  [NG];
    logic               co_n  [NG];
    logic [WIDTH-1:0]   sum_n [NG];

    // Subtraction is A + ~B + ~cin, folded in before the first stage.
    assign eb = b ^ {WIDTH{sub}};
    assign ec = cin ^ sub;

    // The whole pipeline moves together whenever the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 reads the live operands; later stages read their nibble from the skew registers.
    always_comb begin
        for (int k = 0; k < NG; k++) begin
            grp_a[k] = '0;
            grp_b[k] = '0;
            grp_c[k] = 1'b0;
        end
        grp_a[0] = a[GROUP_W-1:0];
        grp_b[0] = eb[GROUP_W-1:0];
        grp_c[0] = ec;
        for (int k = 1; k < NG; k++) begin
            grp_a[k] = a_sk[k-1][GROUP_W*k +: GROUP_W];
            grp_b[k] = b_sk[k-1][GROUP_W*k +: GROUP_W];
            grp_c[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a4 (grp_a[k]),
            .b4 (grp_b[k]),
            .c  (grp_c[k]),
            .s4 (s_n[k]),
            .p  (p_n[k]),
            .g  (g_n[k]),
            .c3 (c3_n[k]),
            .co (co_n[k])
        );
    end

    // Each stage drops its fresh nibble into the partial sum carried from the stage before.
    always_comb begin
        for (int k = 0; k < NG; k++) begin
            sum_n[k] = '0;
        end
        sum_n[0][GROUP_W-1:0] = s_n[0];
        for (int k = 1; k < NG; k++) begin
            sum_n[k] = sum_dk[k-1];
            sum_n[k][GROUP_W*k +: GROUP_W] = s_n[k];
        end
    end

    // Pipeline registers: cleared on reset, frozen together when the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            zero_q   <= 1'b0;
            for (int k = 0; k < NG; k++) begin
                a_sk[k]   <= '0;
                b_sk[k]   <= '0;
                sum_dk[k] <= '0;
                c_q[k]    <= 1'b0;
                c3_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            vld_pipe[0] <= in_valid;
            a_sk[0]     <= a;
            b_sk[0]     <= eb;
            for (int k = 1; k < NG; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                a_sk[k]     <= a_sk[k-1];
                b_sk[k]     <= b_sk[k-1];
            end
            for (int k = 0; k < NG; k++) begin
                sum_dk[k] <= sum_n[k];
                c3_q[k]   <= c3_n[k];
                // Inner stages chain the P/G group carry; the last stage keeps the group's co
                // as cout (the two are the same function).
                if (k == NG - 1) c_q[k] <= co_n[k];
                else             c_q[k] <= g_n[k] | (p_n[k] & grp_c[k]);
            end
            zero_q <= (sum_n[NG-1] == '0);
        end
    end

    assign out_valid = vld_pipe[NG-1];
    assign sum       = sum_dk[NG-1];
    assign cout      = c_q[NG-1];
    assign ovf       = c3_q[NG-1] ^ c_q[NG-1];
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=16 (latency 4).
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int NG = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   lat_en = 1'b1;
    bit   hold_v = 1'b0;
    logic [W-1:0] h_sum;
    logic [2:0]   h_flags;
    exp_t sb[$];
    exp_t mon_e;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        exp_t         e;
        logic [W-1:0] beff;
        logic [W:0]   full;
        beff  = ms ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, mc ^ ms};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.o   = (ma[W-1] == beff[W-1]) && (e.s[W-1] != ma[W-1]);
        e.z   = (e.s == '0);
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.s = s; e.c = c; e.o = o; e.z = z; e.acc = 0;
        return e;
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_sum", {16'b0, sum}, {16'b0, h_sum});
                chk("hold_flags", {29'b0, cout, ovf, zero}, {29'b0, h_flags});
            end
            if (out_valid && !out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sum", {16'b0, sum}, {16'b0, mon_e.s});
                    chk("cout", {31'b0, cout}, {31'b0, mon_e.c});
                    chk("ovf", {31'b0, ovf}, {31'b0, mon_e.o});
                    chk("zero", {31'b0, zero}, {31'b0, mon_e.z});
                    if (lat_en) chk("latency", cyc - mon_e.acc, NG);
                end
            end
            hold_v  <= out_valid && !out_ready;
            h_sum   <= sum;
            h_flags <= {cout, ovf, zero};
        end
    end

    // Present one operand set and hold it until accepted; out_ready follows stall_left.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input exp_t e);
        bit done = 1'b0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #2;
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end
        if (!done) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && sb.size() > 0; n++) begin
            @(posedge clk); #2;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic send_rand();
        logic [W-1:0] ra, rb;
        logic rc, rs;
        ra = W'($urandom); rb = W'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    initial begin
        // Test 1: reset values, then an asynchronous reset while a result is held.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        stall_left = 40;
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #2;
        end
        chk("held_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #4;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_sum", {16'b0, sum}, 32'd0);
        chk("arst_flags", {29'b0, cout, ovf, zero}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        stall_left = 0;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Tests 2-4: directed add, full ripple, overflow, subtract.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        send(16'h0009, 16'h0003, 1'b1, 1'b1, mk(16'h0005, 1'b1, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        drain();

        // Test 5a: back-to-back random stream, one result per cycle.
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // Test 5b: same with a 3-cycle output stall mid-stream.
        lat_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) stall_left = 3;
            send_rand();
        end
        drain();
        lat_en = 1'b1;

        // Test 6: reset with operations in flight; only the post-reset op may emerge.
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("flight_rst_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #2;
        end
        send(16'hABCD, 16'h1111, 1'b0, 1'b1, mk(16'h9ABC, 1'b1, 1'b0, 1'b0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
